mem_bus_arbiter: RTL
====================

// Module: mem_bus_arbiter
// PURPOSE
// Two-master sequencer for the shared data-memory bus in front of the chipset address decoder.
// Master 0 is the CPU data port; master 1 is the loader/DMA port.
// Grants one access at a time, round-robin, and drives DataAdr/WriteData/MemWrite to the decoder.
// Inserts per-region wait states and returns read data with a one-cycle ready/err pulse.
// PARAMETERS
// N         32       address/data width
// ROM_WAIT  1        extra ACCESS cycles for ROM  (0x4000..0x4400 inclusive)
// RAM_WAIT  1        extra ACCESS cycles for RAM  (0x4600..0x5000 inclusive)
// FF_WAIT   0        extra ACCESS cycles for FF   (>= 0x5200)
// PORTS
// clk        in   1   system clock, all state on rising edge
// reset      in   1   synchronous, active-high
// m0_req     in   1   master 0 request; held with adr/we/wdata stable until m0_ready
// m0_we      in   1   master 0 write (1) / read (0)
// m0_adr     in   N   master 0 byte address
// m0_wdata   in   N   master 0 write data
// m0_rdata   out  N   master 0 read data, valid while m0_ready=1
// m0_ready   out  1   one-cycle completion pulse to master 0
// m0_err     out  1   with m0_ready: unmapped address or write to ROM
// m1_*       --   --  identical set for master 1 (req, we, adr, wdata, rdata, ready, err)
// DataAdr    out  N   address to decoder/memories
// WriteData  out  N   write data to RAM/FF
// MemWrite   out  1   write strobe to decoder, one cycle per write
// ReadData   in   N   decoder-muxed read data (ROM/RAM/FF by select)
// BEHAVIOUR
// - Reset: state=IDLE; DataAdr, WriteData, m*_rdata = 0; MemWrite, m*_ready, m*_err = 0;
//   last_grant=1 (master 0 wins the first tie). Reset mid-access aborts it: no MemWrite, no ready.
// - FSM IDLE -> ACCESS -> RESP -> IDLE; single outstanding access, no pipelining.
// - IDLE: no req -> stay. Only one req -> grant it. Both req -> grant !last_grant.
//   Grant latches adr/we/wdata/master id, decodes region, updates last_grant.
//   Mapped and legal -> ACCESS, cnt=region WAIT. Unmapped, or we=1 to ROM -> RESP with err=1.
// - ACCESS: DataAdr/WriteData driven from latched values the whole state.
//   cnt!=0 -> cnt-1. cnt==0 -> sample ReadData into rdata reg (reads only);
//   MemWrite=1 this cycle only if we -> RESP.
// - RESP: granted master's ready=1 (and err if flagged) for exactly one cycle; other master's
//   ready/err=0 -> IDLE.
// - Read data: rdata is registered and holds until that master's next completion.
//   Writes return rdata=0.
// - Latency: req seen in IDLE at cycle 0 -> ready at cycle WAIT+2; error path -> ready at cycle 1.
// - Transfer completes at the edge where ready=1. The master then drops req or presents a new
//   request next cycle. A new request is arbitrated in that IDLE cycle (back-to-back is legal).
// - Fairness: continuous req on both -> strict alternation 0,1,0,1...
// - Address decode uses exactly the inclusive bounds above.
//   0x4401..0x45FF and 0x5001..0x51FF are unmapped.
// - MemWrite never asserted outside ACCESS and never for ROM or unmapped addresses.
// - No combinational path from m*_req to any output; all outputs are registered.
// TESTING
// - M0 read 0x4600 (RAM_WAIT=1), ReadData=0xCAFE0001 -> DataAdr=0x4600 in cycles 1-2,
//   m0_ready at cycle 3, m0_rdata=0xCAFE0001, m0_err=0.
// - M1 write 0x5200 data 0x5 (FF_WAIT=0) -> MemWrite=1 in cycle 1 only, WriteData=0x5,
//   m1_ready at cycle 2.
// - Both req every cycle from reset -> grant order 0,1,0,1. Each ready pulses once per access;
//   never both readies in the same cycle.
// - M0 write 0x4100 (ROM) -> no MemWrite; m0_ready=1, m0_err=1 at cycle 1.
//   Read 0x4500 -> same err response.
// - Reset asserted during ACCESS of a RAM write -> no MemWrite, no ready; all outputs 0
//   next cycle. First post-reset tie goes to master 0.
// - Back-to-back M0 reads 0x4000 then 0x5000 with req held -> second grant in the IDLE cycle
//   after the first ready; both return correct data.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
//
// Two-master sequencer for the shared data-memory bus that sits in front of the
// chipset address decoder. Master 0 is the CPU data port, master 1 is the
// loader/DMA port. One access is in flight at a time; ties are broken
// round-robin. The block inserts per-region wait states, drives the decoder
// address/data/strobe, and returns read data with a one-cycle ready/err pulse.
//
// Access flow: IDLE -> ACCESS -> RESP -> IDLE (illegal requests skip ACCESS).
//   req seen in IDLE at cycle 0 -> ready at cycle WAIT+2; error -> ready at 1.
//
// Address map (inclusive bounds):
//   ROM 0x4000..0x4400   RAM 0x4600..0x5000   FF >= 0x5200   everything else unmapped
//
// Ports
//   clk        in   1   system clock, rising edge
//   reset      in   1   synchronous, active-high
//   m0_req     in   1   master 0 request, held stable until m0_ready
//   m0_we      in   1   master 0 write (1) / read (0)
//   m0_adr     in   N   master 0 byte address
//   m0_wdata   in   N   master 0 write data
//   m0_rdata   out  N   master 0 read data, valid while m0_ready=1
//   m0_ready   out  1   one-cycle completion pulse to master 0
//   m0_err     out  1   with m0_ready: unmapped address or write to ROM
//   m1_*                same set for master 1
//   DataAdr    out  N   address to decoder/memories
//   WriteData  out  N   write data to RAM/FF
//   MemWrite   out  1   write strobe, one cycle per write
//   ReadData   in   N   decoder-muxed read data
// -----------------------------------------------------------------------------
module mem_bus_arbiter #(
   parameter int N        = 32,
   parameter int ROM_WAIT = 1,
   parameter int RAM_WAIT = 1,
   parameter int FF_WAIT  = 0
) (
   input  logic         clk,
   input  logic         reset,

   input  logic         m0_req,
   input  logic         m0_we,
   input  logic [N-1:0] m0_adr,
   input  logic [N-1:0] m0_wdata,
   output logic [N-1:0] m0_rdata,
   output logic         m0_ready,
   output logic         m0_err,

   input  logic         m1_req,
   input  logic         m1_we,
   input  logic [N-1:0] m1_adr,
   input  logic [N-1:0] m1_wdata,
   output logic [N-1:0] m1_rdata,
   output logic         m1_ready,
   output logic         m1_err,

   output logic [N-1:0] DataAdr,
   output logic [N-1:0] WriteData,
   output logic         MemWrite,
   input  logic [N-1:0] ReadData
);

   // Wait-state counter width; comfortably covers any sensible wait setting.
   localparam int CW = 8;

   localparam logic [CW-1:0] ROM_WAIT_C = CW'(ROM_WAIT);
   localparam logic [CW-1:0] RAM_WAIT_C = CW'(RAM_WAIT);
   localparam logic [CW-1:0] FF_WAIT_C  = CW'(FF_WAIT);

   localparam logic [N-1:0] ROM_LO = N'(32'h0000_4000);
   localparam logic [N-1:0] ROM_HI = N'(32'h0000_4400);
   localparam logic [N-1:0] RAM_LO = N'(32'h0000_4600);
   localparam logic [N-1:0] RAM_HI = N'(32'h0000_5000);
   localparam logic [N-1:0] FF_LO  = N'(32'h0000_5200);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCESS,
      S_RESP
   } state_t;

   typedef enum logic [1:0] {
      R_NONE,
      R_ROM,
      R_RAM,
      R_FF
   } region_t;

   // ---------------------------------------------------------------------------
   // Registered state and outputs
   // ---------------------------------------------------------------------------
   state_t          state_q;
   logic            last_grant_q;   // master granted most recently
   logic            gnt_id_q;       // master owning the current access
   logic            we_q;           // latched direction of the current access
   logic [CW-1:0]   cnt_q;          // remaining extra ACCESS cycles

   logic [N-1:0]    data_adr_q;
   logic [N-1:0]    write_data_q;
   logic            mem_write_q;
   logic [N-1:0]    m0_rdata_q;
   logic [N-1:0]    m1_rdata_q;
   logic            m0_ready_q;
   logic            m1_ready_q;
   logic            m0_err_q;
   logic            m1_err_q;

   // ---------------------------------------------------------------------------
   // Arbitration and decode of the candidate request (used only in IDLE)
   // ---------------------------------------------------------------------------
   logic            sel_valid;
   logic            sel_id;
   logic            sel_we;
   logic [N-1:0]    sel_adr;
   logic [N-1:0]    sel_wdata;
   region_t         sel_region;
   logic [CW-1:0]   sel_wait;
   logic            sel_illegal;

   // NOTE: every signal assigned in always_comb gets a default at the top so
   // that no path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      sel_valid  = m0_req | m1_req;
      // On a tie the master that did not win last time goes next.
      sel_id     = (m0_req & m1_req) ? ~last_grant_q : m1_req;
      sel_we     = sel_id ? m1_we    : m0_we;
      sel_adr    = sel_id ? m1_adr   : m0_adr;
      sel_wdata  = sel_id ? m1_wdata : m0_wdata;

      sel_region = R_NONE;
      if ((sel_adr >= ROM_LO) && (sel_adr <= ROM_HI)) begin
         sel_region = R_ROM;
      end else if ((sel_adr >= RAM_LO) && (sel_adr <= RAM_HI)) begin
         sel_region = R_RAM;
      end else if (sel_adr >= FF_LO) begin
         sel_region = R_FF;
      end

      sel_wait = '0;
      case (sel_region)
         R_ROM:   sel_wait = ROM_WAIT_C;
         R_RAM:   sel_wait = RAM_WAIT_C;
         R_FF:    sel_wait = FF_WAIT_C;
         default: sel_wait = '0;
      endcase

      // Holes in the map and any ROM write are answered with an error
      // response and never reach the decoder.
      sel_illegal = (sel_region == R_NONE) | ((sel_region == R_ROM) & sel_we);
   end

   // ---------------------------------------------------------------------------
   // Sequencer
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values of the others and the result does not
   // depend on statement order or on the order simulators evaluate processes.
   always_ff @(posedge clk) begin
      if (reset) begin
         // Returned read data is cleared as well: masters observe zeros after a
         // reset rather than data left over from an aborted transfer.
         state_q      <= S_IDLE;
         last_grant_q <= 1'b1;          // master 0 wins the first tie
         gnt_id_q     <= 1'b0;
         we_q         <= 1'b0;
         cnt_q        <= '0;
         data_adr_q   <= '0;
         write_data_q <= '0;
         mem_write_q  <= 1'b0;
         m0_rdata_q   <= '0;
         m1_rdata_q   <= '0;
         m0_ready_q   <= 1'b0;
         m1_ready_q   <= 1'b0;
         m0_err_q     <= 1'b0;
         m1_err_q     <= 1'b0;
      end else begin
         // Strobes and response pulses last a single cycle unless re-armed.
         mem_write_q <= 1'b0;
         m0_ready_q  <= 1'b0;
         m1_ready_q  <= 1'b0;
         m0_err_q    <= 1'b0;
         m1_err_q    <= 1'b0;

         case (state_q)
            S_IDLE: begin
               if (sel_valid) begin
                  gnt_id_q     <= sel_id;
                  last_grant_q <= sel_id;
                  we_q         <= sel_we;
                  if (sel_illegal) begin
                     // Error response goes out next cycle; the bus is untouched.
                     state_q <= S_RESP;
                     if (sel_id) begin
                        m1_ready_q <= 1'b1;
                        m1_err_q   <= 1'b1;
                        m1_rdata_q <= '0;
                     end else begin
                        m0_ready_q <= 1'b1;
                        m0_err_q   <= 1'b1;
                        m0_rdata_q <= '0;
                     end
                  end else begin
                     state_q      <= S_ACCESS;
                     cnt_q        <= sel_wait;
                     data_adr_q   <= sel_adr;
                     write_data_q <= sel_wdata;
                     // The strobe must coincide with the last ACCESS cycle;
                     // with no wait states that is the very first one.
                     mem_write_q  <= sel_we & (sel_wait == '0);
                  end
               end
            end

            S_ACCESS: begin
               if (cnt_q != '0) begin
                  cnt_q       <= cnt_q - CW'(1);
                  // Arm the strobe for the final ACCESS cycle.
                  mem_write_q <= we_q & (cnt_q == CW'(1));
               end else begin
                  state_q <= S_RESP;
                  if (gnt_id_q) begin
                     m1_ready_q <= 1'b1;
                     m1_rdata_q <= we_q ? '0 : ReadData;
                  end else begin
                     m0_ready_q <= 1'b1;
                     m0_rdata_q <= we_q ? '0 : ReadData;
                  end
               end
            end

            S_RESP: begin
               // Ready is showing this cycle; the defaults above end the pulse.
               state_q <= S_IDLE;
            end

            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs (all registered)
   // ---------------------------------------------------------------------------
   assign DataAdr   = data_adr_q;
   assign WriteData = write_data_q;
   assign MemWrite  = mem_write_q;
   assign m0_rdata  = m0_rdata_q;
   assign m1_rdata  = m1_rdata_q;
   assign m0_ready  = m0_ready_q;
   assign m1_ready  = m1_ready_q;
   assign m0_err    = m0_err_q;
   assign m1_err    = m1_err_q;

endmodule
